// File: rtl/sram_pin_responder_if.sv
// ---------------------------------------------------------------------------
// sram_pin_responder_if
// Pin-level bundle between an SRAM controller (master) and the behavioural
// SRAM responder (slave).
//   SRAM_CS_Pin        master->slave  chip select, active-low
//   SRAM_WR_Pin        master->slave  write strobe, active-low (1 = read)
//   SRAM_ADDR_Pin      master->slave  word address, ADDRW bits
//   SRAM_DATA_IN_Pin   master->slave  write data, DATAW bits
//   SRAM_DATA_OUT_Pin  slave->master  read data, zero when not valid
//   data_out_en        slave->master  read data valid
//   err_range          slave->master  sticky out-of-range access flag
//   err_contention     slave->master  sticky write-during-read flag
//   rd_cnt / wr_cnt    slave->master  accepted access counters (16 bits)
// ---------------------------------------------------------------------------
interface sram_pin_responder_if #(
  parameter int ADDRW = 19,
  parameter int DATAW = 32
);
  logic             SRAM_CS_Pin;
  logic             SRAM_WR_Pin;
  logic [ADDRW-1:0] SRAM_ADDR_Pin;
  logic [DATAW-1:0] SRAM_DATA_IN_Pin;
  logic [DATAW-1:0] SRAM_DATA_OUT_Pin;
  logic             data_out_en;
  logic             err_range;
  logic             err_contention;
  logic [15:0]      rd_cnt;
  logic [15:0]      wr_cnt;

  modport master (
    output SRAM_CS_Pin, SRAM_WR_Pin, SRAM_ADDR_Pin, SRAM_DATA_IN_Pin,
    input  SRAM_DATA_OUT_Pin, data_out_en, err_range, err_contention,
           rd_cnt, wr_cnt
  );

  modport slave (
    input  SRAM_CS_Pin, SRAM_WR_Pin, SRAM_ADDR_Pin, SRAM_DATA_IN_Pin,
    output SRAM_DATA_OUT_Pin, data_out_en, err_range, err_contention,
           rd_cnt, wr_cnt
  );
endinterface

// File: rtl/sram_pin_responder.sv
// ---------------------------------------------------------------------------
// sram_pin_responder
// Behavioural SRAM device model answering a pin-level controller. Writes
// land in storage at the sampling edge; reads are fully pipelined and return
// data RD_LAT cycles after acceptance, in order, one per cycle.
// Ports:
//   CLK   single clock, rising edge
//   RSTn  synchronous active-low reset (storage array is not reset)
//   bus   sram_pin_responder_if.slave pin bundle
// Parameters: ADDRW (pin address width), DATAW (data width), DEPTHW
//   (2^DEPTHW words implemented), RD_LAT (1..4 read latency).
// Optional feature: define SRAM_RESP_STATS_EN to build saturating 16-bit
//   read/write counters; otherwise rd_cnt/wr_cnt are constant zero.
// ---------------------------------------------------------------------------
module sram_pin_responder #(
  parameter int ADDRW  = 19,
  parameter int DATAW  = 32,
  parameter int DEPTHW = 10,
  parameter int RD_LAT = 2
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  sram_pin_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  logic [DATAW-1:0] mem_q [2**DEPTHW];

  state_e              state_q, state_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [DATAW-1:0]    dat_q [RD_LAT];
  logic [DATAW-1:0]    dat_d [RD_LAT];
  logic                err_range_q, err_range_d;
  logic                err_cont_q, err_cont_d;

  logic                req_wr, req_rd, out_of_range, mem_we;
  logic [DEPTHW-1:0]   idx;

  // Request decode, read pipeline shift and sticky error flags.
  always_comb begin
    req_wr       = !bus.SRAM_CS_Pin && !bus.SRAM_WR_Pin;
    req_rd       = !bus.SRAM_CS_Pin &&  bus.SRAM_WR_Pin;
    // Any address bit above the implemented depth makes the access invalid.
    out_of_range = |(bus.SRAM_ADDR_Pin >> DEPTHW);
    idx          = bus.SRAM_ADDR_Pin[DEPTHW-1:0];
    mem_we       = req_wr && !out_of_range;

    if (req_wr) begin
      state_d = ST_WRITE;
    end else if (req_rd) begin
      state_d = ST_READ;
    end else begin
      state_d = ST_IDLE;
    end

    // Stage 0 captures storage at acceptance; a write sampled on an earlier
    // edge is already in mem_q, which gives read-after-write for free.
    vld_d    = vld_q;
    vld_d[0] = req_rd;
    for (int i = 0; i < RD_LAT; i++) begin
      dat_d[i] = dat_q[i];
    end
    dat_d[0] = (req_rd && !out_of_range) ? mem_q[idx] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end

    err_range_d = err_range_q | ((req_rd || req_wr) && out_of_range);
    // A read is in flight whenever any pipeline stage holds a valid entry;
    // a READ->WRITE bus transition always falls into that case.
    err_cont_d  = err_cont_q |
                  (req_wr && ((|vld_q) || (state_q == ST_READ)));
  end

  // Control, pipeline and flag registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      vld_q       <= '0;
      err_range_q <= 1'b0;
      err_cont_q  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      err_range_q <= err_range_d;
      err_cont_q  <= err_cont_d;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // Storage array: never reset, writes blocked while reset is asserted.
  always_ff @(posedge CLK) begin
    if (RSTn && mem_we) begin
      mem_q[idx] <= bus.SRAM_DATA_IN_Pin;
    end
  end

  // Invalid stages carry zero data, so the last stage drives the pins as is.
  assign bus.SRAM_DATA_OUT_Pin = dat_q[RD_LAT-1];
  assign bus.data_out_en       = vld_q[RD_LAT-1];
  assign bus.err_range         = err_range_q;
  assign bus.err_contention    = err_cont_q;

`ifdef SRAM_RESP_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  // Saturating access counters; out-of-range accesses are counted too.
  always_comb begin
    if (req_rd && (rd_cnt_q != 16'hFFFF)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
    if (req_wr && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;
`else
  assign bus.rd_cnt = 16'd0;
  assign bus.wr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sram_pin_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_pin_responder
// Directed bench for sram_pin_responder with default parameters
// (ADDRW=19, DATAW=32, DEPTHW=10, RD_LAT=2). A vector table covers the
// basic write/read/pipelining behaviour; hand sequences cover out-of-range,
// contention, reset during a read and the access counters.
// ---------------------------------------------------------------------------
module tb_sram_pin_responder;

  localparam int ADDRW  = 19;
  localparam int DATAW  = 32;
  localparam int DEPTHW = 10;
  localparam int RD_LAT = 2;

  logic CLK;
  logic RSTn;

  int checks;
  int errors;

  sram_pin_responder_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  sram_pin_responder #(
    .ADDRW (ADDRW),
    .DATAW (DATAW),
    .DEPTHW(DEPTHW),
    .RD_LAT(RD_LAT)
  ) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic             cs;
    logic             wr;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] din;
    logic             exp_en;
    logic [DATAW-1:0] exp_dout;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic cs, logic wr, logic [ADDRW-1:0] addr,
                              logic [DATAW-1:0] din, logic en,
                              logic [DATAW-1:0] dout);
    vec_t v;
    v.cs = cs; v.wr = wr; v.addr = addr; v.din = din;
    v.exp_en = en; v.exp_dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cs, input logic wr,
                       input logic [ADDRW-1:0] addr, input logic [DATAW-1:0] din);
    bus.SRAM_CS_Pin      = cs;
    bus.SRAM_WR_Pin      = wr;
    bus.SRAM_ADDR_Pin    = addr;
    bus.SRAM_DATA_IN_Pin = din;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 19'd0, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Columns: cs, wr, addr, din, expected en / data after this edge.
    vecs[0]  = mk(1'b0, 1'b0, 19'h0, 32'h12345678, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 1'b0, 19'h5, 32'hDEADBEEF, 1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 1'b1, 19'h5, 32'h0,        1'b0, 32'h0);
    vecs[3]  = mk(1'b1, 1'b1, 19'h0, 32'h0,        1'b1, 32'hDEADBEEF);
    vecs[4]  = mk(1'b1, 1'b1, 19'h0, 32'h0,        1'b0, 32'h0);
    vecs[5]  = mk(1'b0, 1'b0, 19'h1, 32'h11,       1'b0, 32'h0);
    vecs[6]  = mk(1'b0, 1'b0, 19'h2, 32'h22,       1'b0, 32'h0);
    vecs[7]  = mk(1'b0, 1'b0, 19'h3, 32'h33,       1'b0, 32'h0);
    vecs[8]  = mk(1'b0, 1'b1, 19'h1, 32'h0,        1'b0, 32'h0);
    vecs[9]  = mk(1'b0, 1'b1, 19'h2, 32'h0,        1'b1, 32'h11);
    vecs[10] = mk(1'b0, 1'b1, 19'h3, 32'h0,        1'b1, 32'h22);
    vecs[11] = mk(1'b1, 1'b1, 19'h0, 32'h0,        1'b1, 32'h33);
    vecs[12] = mk(1'b1, 1'b1, 19'h0, 32'h0,        1'b0, 32'h0);
    vecs[13] = mk(1'b0, 1'b0, 19'h9, 32'hA5A5A5A5, 1'b0, 32'h0);
    vecs[14] = mk(1'b0, 1'b1, 19'h9, 32'h0,        1'b0, 32'h0);
    vecs[15] = mk(1'b1, 1'b1, 19'h0, 32'h0,        1'b1, 32'hA5A5A5A5);
    vecs[16] = mk(1'b1, 1'b1, 19'h0, 32'h0,        1'b0, 32'h0);
    vecs[17] = mk(1'b0, 1'b0, 19'h7, 32'h77,       1'b0, 32'h0);
    vecs[18] = mk(1'b1, 1'b0, 19'h7, 32'hFFFFFFFF, 1'b0, 32'h0);

    // Reset state.
    RSTn = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_en",   {31'd0, bus.data_out_en}, 32'd0);
    chk("rst_dout", bus.SRAM_DATA_OUT_Pin, 32'd0);
    chk("rst_erng", {31'd0, bus.err_range}, 32'd0);
    chk("rst_ecnt", {31'd0, bus.err_contention}, 32'd0);
    chk("rst_rdc",  {16'd0, bus.rd_cnt}, 32'd0);
    chk("rst_wrc",  {16'd0, bus.wr_cnt}, 32'd0);
    RSTn = 1'b1;

    // Table-driven basic behaviour.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].din);
      tick();
      chk($sformatf("vec%0d_en", i), {31'd0, bus.data_out_en}, {31'd0, vecs[i].exp_en});
      chk($sformatf("vec%0d_dout", i), bus.SRAM_DATA_OUT_Pin, vecs[i].exp_dout);
    end
    chk("tbl_erng", {31'd0, bus.err_range}, 32'd0);
    chk("tbl_ecnt", {31'd0, bus.err_contention}, 32'd0);

    // Out-of-range write is discarded; out-of-range read returns zero.
    drive(1'b0, 1'b0, 19'h400, 32'hFFFF0000);
    tick();
    chk("oor_flag", {31'd0, bus.err_range}, 32'd1);
    drive(1'b0, 1'b1, 19'h400, 32'h0);
    tick();
    idle();
    tick();
    chk("oor_rd_en",   {31'd0, bus.data_out_en}, 32'd1);
    chk("oor_rd_dout", bus.SRAM_DATA_OUT_Pin, 32'h0);
    drive(1'b0, 1'b1, 19'h0, 32'h0);
    tick();
    idle();
    tick();
    chk("addr0_en",   {31'd0, bus.data_out_en}, 32'd1);
    chk("addr0_dout", bus.SRAM_DATA_OUT_Pin, 32'h12345678);
    tick();

    // Write right after a read: contention flagged, read still delivered.
    chk("pre_ecnt", {31'd0, bus.err_contention}, 32'd0);
    drive(1'b0, 1'b1, 19'h7, 32'h0);
    tick();
    drive(1'b0, 1'b0, 19'h8, 32'h88);
    tick();
    chk("cont_flag", {31'd0, bus.err_contention}, 32'd1);
    chk("cont_en",   {31'd0, bus.data_out_en}, 32'd1);
    chk("cont_dout", bus.SRAM_DATA_OUT_Pin, 32'h77);
    idle();
    tick();
    chk("cont_after_en", {31'd0, bus.data_out_en}, 32'd0);
    drive(1'b0, 1'b1, 19'h8, 32'h0);
    tick();
    idle();
    tick();
    chk("addr8_dout", bus.SRAM_DATA_OUT_Pin, 32'h88);
    tick();

    // Reset with a read in flight; write during reset must be ignored.
    drive(1'b0, 1'b1, 19'h5, 32'h0);
    tick();
    RSTn = 1'b0;
    drive(1'b0, 1'b0, 19'h5, 32'hBADBAD00);
    tick();
    chk("mid_rst_en",   {31'd0, bus.data_out_en}, 32'd0);
    chk("mid_rst_dout", bus.SRAM_DATA_OUT_Pin, 32'd0);
    chk("mid_rst_erng", {31'd0, bus.err_range}, 32'd0);
    chk("mid_rst_ecnt", {31'd0, bus.err_contention}, 32'd0);
    tick();
    RSTn = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_en%0d", i), {31'd0, bus.data_out_en}, 32'd0);
    end
    drive(1'b0, 1'b1, 19'h5, 32'h0);
    tick();
    idle();
    tick();
    chk("keep_en",   {31'd0, bus.data_out_en}, 32'd1);
    chk("keep_dout", bus.SRAM_DATA_OUT_Pin, 32'hDEADBEEF);

    // Counters: three writes, then enough reads to saturate.
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 19'(10 + i), 32'(i + 1));
      tick();
    end
    idle();
    tick();
`ifdef SRAM_RESP_STATS_EN
    chk("wr_cnt", {16'd0, bus.wr_cnt}, 32'd3);
`else
    chk("wr_cnt", {16'd0, bus.wr_cnt}, 32'd0);
`endif
    drive(1'b0, 1'b1, 19'h0, 32'h0);
    for (int i = 0; i < 70000; i++) begin
      tick();
    end
    idle();
    tick();
`ifdef SRAM_RESP_STATS_EN
    chk("rd_cnt", {16'd0, bus.rd_cnt}, 32'h0000FFFF);
`else
    chk("rd_cnt", {16'd0, bus.rd_cnt}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_pin_responder.md
SRAM_PIN_RESPONDER -- requirements
Module: sram_pin_responder

Interface
REQ-001 SHALL have parameter ADDRW, default 19, pin address width.
REQ-002 SHALL have parameter DATAW, default 32, pin data width.
REQ-003 SHALL have parameter DEPTHW, default 10, implemented storage depth 2^DEPTHW words.
REQ-004 SHALL have parameter RD_LAT, default 2, range 1..4, read latency in cycles.
REQ-005 Port: CLK  in  1  single clock; all logic on rising edge.
REQ-006 Port: RSTn  in  1  reset, synchronous, active-low.
REQ-007 Port: SRAM_CS_Pin  in  1  chip select, active-low.
REQ-008 Port: SRAM_WR_Pin  in  1  write strobe, active-low; 1 with CS low means read.
REQ-009 Port: SRAM_ADDR_Pin  in  ADDRW  word address.
REQ-010 Port: SRAM_DATA_IN_Pin  in  DATAW  write data driven by controller.
REQ-011 Port: SRAM_DATA_OUT_Pin  out  DATAW  read data returned to controller.
REQ-012 Port: data_out_en  out  1  high when SRAM_DATA_OUT_Pin carries valid read data.
REQ-013 Port: err_range  out  1  sticky, access with address beyond storage.
REQ-014 Port: err_contention  out  1  sticky, write accepted while read in flight.
REQ-015 Port: rd_cnt / wr_cnt  out  16 each  accepted read/write counts (present only per REQ-033).

Function
REQ-016 Request sampled each rising edge: CS=0,WR=0 -> write; CS=0,WR=1 -> read; CS=1 -> idle.
REQ-017 Write: mem[ADDR[DEPTHW-1:0]] <= DATA_IN at the sampling edge; no response on DATA_OUT.
REQ-018 Read: accepted at edge N; data valid on SRAM_DATA_OUT_Pin with data_out_en=1 during cycle after edge N+RD_LAT-1 (RD_LAT cycles after acceptance).
REQ-019 Reads SHALL be fully pipelined: one read accepted per cycle, responses returned in order, one per cycle.
REQ-020 Read-after-write: read accepted at edge N+1 after write at edge N returns the new data.
REQ-021 Pending reads complete even if CS deasserts or a write arrives after acceptance.
REQ-022 data_out_en=0 and SRAM_DATA_OUT_Pin=0 in any cycle with no valid response.
REQ-023 Address with any bit in ADDR[ADDRW-1:DEPTHW] set: write discarded, read returns all-zero data with data_out_en=1 at normal latency, err_range set.
REQ-024 Write accepted while any read valid in the pipeline: write performed, err_contention set.
REQ-025 Bus FSM states IDLE, WRITE, READ; next state = request type sampled that edge; READ->WRITE transition with pipeline non-empty is the contention event of REQ-024.
REQ-026 Read of never-written in-range location returns undefined data; bench SHALL not check it.

Reset
REQ-027 RSTn=0 at an edge: FSM -> IDLE, read pipeline flushed, data_out_en=0, SRAM_DATA_OUT_Pin=0, err_range=0, err_contention=0, counters=0.
REQ-028 Reset mid-read discards in-flight responses; none appear after RSTn returns high.
REQ-029 Storage array SHALL not be reset; contents survive reset.
REQ-030 Requests sampled while RSTn=0 SHALL be ignored (no write to storage).

Configuration
REQ-031 Macro SRAM_RESP_STATS_EN SHALL control access counters.
REQ-032 Defined: rd_cnt/wr_cnt increment per accepted read/write (including out-of-range), saturate at 0xFFFF.
REQ-033 Undefined: rd_cnt/wr_cnt tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-034 RD_LAT=2: write 0xDEADBEEF to addr 0x5 at edge 1, read 0x5 at edge 2 -> data_out_en=1, DATA_OUT=0xDEADBEEF in cycle after edge 3.
REQ-035 Back-to-back reads addr 1,2,3 (data 0x11,0x22,0x33) -> three consecutive valid cycles 0x11,0x22,0x33, then data_out_en=0.
REQ-036 Write addr 0x400 (DEPTHW=10) data 0xFFFF0000 -> err_range=1, addr 0x000 unchanged; read 0x400 -> returns 0x00000000.
REQ-037 Read addr 7 then write addr 8 next edge -> err_contention=1, read response still delivered, addr 8 updated.
REQ-038 Read accepted, RSTn=0 at next edge -> no response afterwards; read of previously written addr after reset returns stored value.
REQ-039 With SRAM_RESP_STATS_EN: 70000 reads -> rd_cnt=0xFFFF; without macro -> rd_cnt=0.
